// File: rtl/activation_pkg.sv
// Shared types and fixed-point breakpoint helpers for the activation datapath.
// Breakpoints are returned as plain integers and sized by the user.
package activation_pkg;

  typedef enum logic [2:0] {
    LINEAR  = 3'd0,
    RELU    = 3'd1,
    SIGMOID = 3'd2,
    TANH    = 3'd3,
    LEAKY   = 3'd4,
    RELU6   = 3'd5
  } act_func_e;

  typedef enum logic [1:0] {
    SEG_LO  = 2'd0,
    SEG_MID = 2'd1,
    SEG_HI  = 2'd2
  } seg_e;

  function automatic int unsigned one_q(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

  function automatic int unsigned sig_knee_lo(input int unsigned frac_w);
    return one_q(frac_w);
  endfunction

  function automatic int unsigned sig_knee_hi(input int unsigned frac_w);
    return 5 * one_q(frac_w);
  endfunction

  function automatic int unsigned tanh_knee_lo(input int unsigned frac_w);
    return one_q(frac_w) / 2;
  endfunction

  function automatic int unsigned tanh_knee_hi(input int unsigned frac_w);
    return (5 * one_q(frac_w)) / 2;
  endfunction

  function automatic int unsigned relu6_cap(input int unsigned frac_w);
    return 6 * one_q(frac_w);
  endfunction

endpackage

// File: rtl/activation_lane.sv
// Combinational per-lane compute between the two pipeline stages:
// piecewise segment math, sign restore, output clamp and saturation flag.
module activation_lane
  import activation_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W:0]   a,
  input  logic              neg,
  input  logic [1:0]        seg,
  input  logic [2:0]        func,
  input  logic [3:0]        leak_shift,
  output logic [DATA_W-1:0] y,
  output logic              sat
);

  localparam int IW = DATA_W + 2;
  localparam logic signed [IW-1:0] ONE  = IW'(one_q(FRAC_W));
  localparam logic signed [IW-1:0] HALF = IW'(one_q(FRAC_W) / 2);
  localparam logic signed [IW-1:0] Q3   = IW'((3 * one_q(FRAC_W)) / 4);
  localparam logic signed [IW-1:0] SIX  = IW'(relu6_cap(FRAC_W));
  localparam logic signed [IW-1:0] MAXV = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV = {3'b111, {(DATA_W-1){1'b0}}};

  logic signed [IW-1:0] xe, ae, f, r;

  always_comb begin
    xe = {{2{x[DATA_W-1]}}, x};
    ae = {1'b0, a};
    f  = '0;
    r  = xe;
    case (func)
      RELU: r = neg ? '0 : xe;
      SIGMOID: begin
        case (seg)
          SEG_LO:  f = HALF + (ae >>> 2);
          SEG_MID: f = Q3 + ((ae - ONE) >>> 4);
          default: f = ONE;
        endcase
        r = neg ? (ONE - f) : f;
      end
      TANH: begin
        case (seg)
          SEG_LO:  f = ae;
          SEG_MID: f = HALF + ((ae - HALF) >>> 2);
          default: f = ONE;
        endcase
        r = neg ? -f : f;
      end
      LEAKY: r = neg ? (xe >>> leak_shift) : xe;
      // ReLU6's cap is a function bound, not a saturation event
      RELU6: r = neg ? '0 : ((xe > SIX) ? SIX : xe);
      default: r = xe;
    endcase
  end

  always_comb begin
    sat = 1'b0;
    y   = r[DATA_W-1:0];
    if (r > MAXV) begin
      sat = 1'b1;
      y   = MAXV[DATA_W-1:0];
    end else if (r < MINV) begin
      sat = 1'b1;
      y   = MINV[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/activation_pipe.sv
// Two-stage multi-lane activation pipeline with valid/ready backpressure
// and a saturating count of beats accepted downstream.
module activation_pipe
  import activation_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [2:0]              in_func,
  input  logic [3:0]              in_leak_shift,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_sat,
  output logic [CNT_W-1:0]        beat_count
);

  localparam logic [DATA_W:0] SIG_K1 = (DATA_W+1)'(sig_knee_lo(FRAC_W));
  localparam logic [DATA_W:0] SIG_K2 = (DATA_W+1)'(sig_knee_hi(FRAC_W));
  localparam logic [DATA_W:0] TH_K1  = (DATA_W+1)'(tanh_knee_lo(FRAC_W));
  localparam logic [DATA_W:0] TH_K2  = (DATA_W+1)'(tanh_knee_hi(FRAC_W));

  logic s1_valid, s2_valid, s1_en, s2_en;
  logic [2:0] s1_func;
  logic [3:0] s1_shift;
  logic [LANES-1:0][DATA_W-1:0] s1_x, res;
  logic [LANES-1:0][DATA_W:0]   abs_d, s1_abs;
  logic [LANES-1:0][1:0]        seg_d, s1_seg;
  logic [LANES-1:0]             neg_d, s1_neg, res_sat;

  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] x_in;
    logic [DATA_W:0]   x_ext;

    // Magnitude is one bit wider so the most negative input stays positive
    assign x_in     = in_data[i*DATA_W +: DATA_W];
    assign x_ext    = {x_in[DATA_W-1], x_in};
    assign neg_d[i] = x_in[DATA_W-1];
    assign abs_d[i] = neg_d[i] ? -x_ext : x_ext;

    always_comb begin
      if (in_func == TANH)
        seg_d[i] = (abs_d[i] < TH_K1) ? SEG_LO : (abs_d[i] < TH_K2) ? SEG_MID : SEG_HI;
      else
        seg_d[i] = (abs_d[i] < SIG_K1) ? SEG_LO : (abs_d[i] < SIG_K2) ? SEG_MID : SEG_HI;
    end

    activation_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
      .x          (s1_x[i]),
      .a          (s1_abs[i]),
      .neg        (s1_neg[i]),
      .seg        (s1_seg[i]),
      .func       (s1_func),
      .leak_shift (s1_shift),
      .y          (res[i]),
      .sat        (res_sat[i])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) s1_valid <= 1'b0;
    else if (s1_en) s1_valid <= in_valid;
  end

  always_ff @(posedge clock) begin
    if (s1_en && in_valid) begin
      s1_x     <= in_data;
      s1_abs   <= abs_d;
      s1_neg   <= neg_d;
      s1_seg   <= seg_d;
      s1_func  <= in_func;
      s1_shift <= in_leak_shift;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_sat  <= res_sat;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) beat_count <= '0;
    else if (out_valid && out_ready && (beat_count != '1))
      beat_count <= beat_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Scoreboard bench for activation_pipe: driver pushes expected beats, a
// negedge monitor pops and compares whenever the DUT hands off a beat.
module tb_activation_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [2:0]  in_func = '0;
  logic [3:0]  in_leak_shift = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [3:0]  out_sat;
  logic [31:0] beat_count;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  sat;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int beats_sent = 0;
  bit rand_ready = 0;
  int edges[12] = '{256, 255, 1280, 1279, 128, 127, 640, 639, -256, -1280, 32767, -32768};

  activation_pipe #(.DATA_W(16), .FRAC_W(8), .LANES(4), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_func(in_func), .in_leak_shift(in_leak_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .beat_count(beat_count)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Reference: activation rules in plain integer arithmetic (Q8.8)
  function automatic int ref_lane(input int x, input int f, input int sh);
    int a, v;
    a = (x < 0) ? -x : x;
    case (f)
      1: return (x < 0) ? 0 : x;
      2: begin
        if (a < 256) v = 128 + a / 4;
        else if (a < 1280) v = 192 + (a - 256) / 16;
        else v = 256;
        return (x >= 0) ? v : 256 - v;
      end
      3: begin
        if (a < 128) v = a;
        else if (a < 640) v = 128 + (a - 128) / 4;
        else v = 256;
        return (x >= 0) ? v : -v;
      end
      4: return (x >= 0) ? x : (x >>> sh);
      5: return (x < 0) ? 0 : ((x > 1536) ? 1536 : x);
      default: return x;
    endcase
  endfunction

  function automatic logic [63:0] model_beat(input logic [63:0] d, input int f, input int sh,
                                             output logic [3:0] sat);
    logic [63:0] o;
    logic signed [15:0] xs;
    int y;
    o = '0;
    sat = '0;
    for (int i = 0; i < 4; i++) begin
      xs = d[i*16 +: 16];
      y = ref_lane(int'(xs), f, sh);
      if (y > 32767) begin y = 32767; sat[i] = 1'b1; end
      if (y < -32768) begin y = -32768; sat[i] = 1'b1; end
      o[i*16 +: 16] = y[15:0];
    end
    return o;
  endfunction

  function automatic logic [15:0] rand_x();
    int v;
    if ($urandom_range(0, 3) == 0) v = edges[$urandom_range(0, 11)];
    else v = int'($urandom_range(0, 65535));
    return v[15:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Drive one beat (inputs change 1 time unit after posedge); push expectation on acceptance
  task automatic send(input logic [63:0] d, input logic [2:0] f, input logic [3:0] s,
                      input logic [63:0] ed, input logic [3:0] es, input bit lat);
    exp_t e;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = d;
    in_func = f;
    in_leak_shift = s;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        e.data = ed; e.sat = es; e.cyc = cyc; e.lat = lat;
        sb.push_back(e);
        beats_sent++;
        break;
      end
      guard++;
      if (guard > 200) begin
        vectors++; errors++;
        $display("FAIL accept_timeout in_ready stuck low, want 1");
        break;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input int f, input bit lat);
    logic [63:0] d, ed;
    logic [3:0] es;
    int sh;
    for (int i = 0; i < 4; i++) d[i*16 +: 16] = rand_x();
    sh = $urandom_range(0, 15);
    ed = model_beat(d, f, sh, es);
    send(d, f[2:0], sh[3:0], ed, es, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 2000) begin @(posedge clock); g++; end
    if (sb.size() != 0) begin
      vectors++; errors++;
      $display("FAIL drain_timeout got %0d beats outstanding want 0", sb.size());
    end
    @(negedge clock);
  endtask

  // Monitor: pops on every downstream handshake and checks stall stability
  initial begin
    exp_t e;
    bit held;
    logic [63:0] hd;
    logic [3:0] hs;
    held = 0; hd = '0; hs = '0;
    forever begin
      @(negedge clock);
      if (reset) begin held = 0; continue; end
      if (out_valid && held) begin
        vectors++;
        if (out_data !== hd || out_sat !== hs) begin
          errors++;
          $display("FAIL stall_hold got %h/%h want %h/%h", out_data, out_sat, hd, hs);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h want none", out_data);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_sat !== e.sat) begin
            errors++;
            $display("FAIL beat_data got %h/%h want %h/%h", out_data, out_sat, e.data, e.sat);
          end
          if (e.lat) begin
            vectors++;
            if (cyc - e.cyc != 2) begin
              errors++;
              $display("FAIL latency got %0d want 2", cyc - e.cyc);
            end
          end
        end
      end
      held = out_valid && !out_ready;
      hd = out_data;
      hs = out_sat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_sat", 64'(out_sat), 64'd0);
    chk("reset_beat_count", 64'(beat_count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;

    // Directed points, back to back with different functions
    send(64'h0000_FE00_0200_0100, 3'd2, 4'd0, 64'h0080_0030_00D0_00C0, 4'h0, 1);
    send(64'hF800_0800_F800_0800, 3'd2, 4'd0, 64'h0000_0100_0000_0100, 4'h0, 1);
    send(64'h0300_FF00_0100_0080, 3'd3, 4'd0, 64'h0100_FF60_00A0_0080, 4'h0, 1);
    send(64'h8000_FFF9_0100_FF00, 3'd4, 4'd3, 64'hF000_FFFF_0100_FFE0, 4'h0, 1);
    send(64'h0100_FFFF_0600_0700, 3'd5, 4'd0, 64'h0100_0000_0600_0600, 4'h0, 1);
    send(64'hFFFF_0001_7FFF_8000, 3'd1, 4'd0, 64'h0000_0001_7FFF_0000, 4'h0, 1);
    send(64'h8000_7FFF_FFFF_1234, 3'd7, 4'd0, 64'h8000_7FFF_FFFF_1234, 4'h0, 1);
    for (int k = 0; k < 8; k++) send_rand(k % 4, 1);
    drain();
    chk("count_after_directed", 64'(beat_count), 64'(beats_sent));

    // Reset with two beats in flight
    @(posedge clock); #1;
    out_ready = 1'b0;
    send_rand(2, 0);
    send_rand(3, 0);
    reset = 1'b1;
    in_valid = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    @(negedge clock);
    chk("reset_mid_out_valid", 64'(out_valid), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    beats_sent = 0;
    @(negedge clock);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    chk("post_reset_count", 64'(beat_count), 64'd0);
    repeat (4) begin
      @(negedge clock);
      chk("post_reset_quiet", 64'(out_valid), 64'd0);
    end
    @(posedge clock); #1;

    // Backpressure stream of 20 beats
    rand_ready = 1;
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      send_rand($urandom_range(0, 7), 0);
    end
    drain();
    rand_ready = 0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("count_backpressure", 64'(beat_count), 64'd20);

    // Longer random soak with random stalls
    @(posedge clock); #1;
    rand_ready = 1;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_rand($urandom_range(0, 7), 0);
    end
    drain();
    rand_ready = 0;
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("count_final", 64'(beat_count), 64'(beats_sent));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/activation_pipe.md
# activation_pipe

Multi-lane, pipelined activation stage for the neural datapath. It sits between the MAC/accumulator output and the next layer's input buffer. It applies one selectable activation function per beat to `LANES` signed fixed-point values under a valid/ready stream handshake. Compared with the single-value registered unit, it adds parametrised width and format, lane parallelism, backpressure, leaky-ReLU and ReLU6 modes, continuous piecewise sigmoid/tanh, output saturation with flags, and a beat counter.

## Interface
Parameters:
- `DATA_W`, 16: signed sample width; legal range 8..32.
- `FRAC_W`, 8: fractional bits. `ONE = 1 << FRAC_W`. Constraint: `FRAC_W + 4 < DATA_W`.
- `LANES`, 4: parallel samples per beat; legal range 1..16.
- `CNT_W`, 32: width of the beat counter.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: the block accepts a beat when `in_valid && in_ready`.
- `in_data` in LANES*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W], signed.
- `in_func` in 3: function code, sampled together with the beat.
- `in_leak_shift` in 4: leaky-ReLU shift, sampled with the beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accept.
- `out_data` out LANES*DATA_W: results, same lane packing as `in_data`.
- `out_sat` out LANES: per-lane flag, set when that lane's result was clamped.
- `beat_count` out CNT_W: number of output beats accepted downstream; saturates at all-ones.

## Operation
- Function codes:
  - 0: linear, y = x.
  - 1: ReLU, y = max(0, x).
  - 2: sigmoid.
  - 3: tanh.
  - 4: leaky ReLU. y = x if x ≥ 0, else x >>> in_leak_shift (arithmetic, floor).
  - 5: ReLU6, y = min(max(0, x), 6·ONE).
  - 6, 7: treated as linear.
- Sigmoid uses a = |x|, computed at DATA_W+1 bits so the most negative input is safe.
  - f(a) = ONE/2 + (a >>> 2) for a < ONE.
  - f(a) = 3·ONE/4 + ((a − ONE) >>> 4) for ONE ≤ a < 5·ONE.
  - f(a) = ONE for a ≥ 5·ONE.
  - y = f(a) for x ≥ 0; y = ONE − f(a) for x < 0. The curve is continuous and symmetric.
- Tanh uses the same a = |x|.
  - g(a) = a for a < ONE/2.
  - g(a) = ONE/2 + ((a − ONE/2) >>> 2) for ONE/2 ≤ a < 5·ONE/2.
  - g(a) = ONE for a ≥ 5·ONE/2.
  - y = g(a) for x ≥ 0; y = −g(a) for x < 0.
- All intermediates are DATA_W+2 bits signed. The final value clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- `out_sat[i]` = 1 when lane i's clamp engaged. ReLU6's upper bound does not count as saturation.
- Function and shift are latched per beat, so consecutive beats may use different functions.

## Timing
- Two register stages.
  - S1 registers abs value, sign, region select, function, shift, and valid.
  - S2 registers the result, sat flags, and valid.
- Latency is 2 cycles from the accepting edge to `out_valid`. Throughput is 1 beat/cycle.
- Stall logic:
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en (combinational)
- A stage holds its contents while its enable is low. No beat is dropped or duplicated under any `out_ready` pattern.
- `out_data`, `out_sat`, and `out_valid` are stable while `out_valid && !out_ready`.
- `beat_count` increments on each cycle with `out_valid && out_ready`. It holds at 2^CNT_W − 1.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_sat` = 0, `beat_count` = 0, and S1 valid = 0. `in_ready` = 1 in the cycle after reset deasserts.
- Reset asserted mid-stream discards both stages' contents on that edge. Inputs presented during reset are not accepted.

## Structure
- `activation_pkg` holds:
  - `act_func_e`: LINEAR=0, RELU=1, SIGMOID=2, TANH=3, LEAKY=4, RELU6=5.
  - Region-select enum for the piecewise segments.
  - Breakpoint helper functions parametrised by FRAC_W.
- Sub-module `activation_lane`: combinational per-lane S1-to-S2 compute (segment math, sign restore, clamp, sat flag), instantiated LANES times.
- `activation_pipe` owns the handshake, the stage registers, and the counter.

## Test plan
All cases use default params, Q8.8.
- Sigmoid, lane inputs 0x0100, 0x0200, 0xFE00, 0x0000 -> 0x00C0, 0x00D0, 0x0030, 0x0080. Inputs 0x0800 and 0xF800 -> 0x0100 and 0x0000.
- Tanh, inputs 0x0080, 0x0100, 0xFF00, 0x0300 -> 0x0080, 0x00A0, 0xFF60, 0x0100.
- Leaky ReLU with shift 3 on 0xFF00 -> 0xFFE0. ReLU6 on 0x0700 -> 0x0600 with out_sat = 0. ReLU on 0x8000 -> 0x0000.
- Backpressure: stream 20 beats with random in_valid and out_ready at ~50%. Required: in-order, lossless output; held output stable during stalls; beat_count = 20.
- Per-beat function switching: alternate codes 0,1,2,3 on back-to-back beats with out_ready = 1. Each result matches its own code; latency is exactly 2 cycles.
- Reset mid-stream with 2 beats in flight -> out_valid = 0 on the next cycle, and those beats never appear; beat_count = 0.
